// File: rtl/simon_control.sv
// Simon game sequencer: synchronises the advance button and steps INPUT/PLAYBACK/REPEAT/DONE.
// Define SIMON_CTRL_AUTOPLAY_EN to drive PLAYBACK and DONE advances from a 2^AUTO_DIV-cycle tick.
module simon_control #(
   parameter int unsigned AUTO_DIV = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       is_legal,
   input  logic       play_gt_count,
   input  logic       repeat_eq_play,
   input  logic       input_eq_pattern,
   output logic [1:0] select,
   output logic [2:0] mode_leds,
   output logic       w_en,
   output logic       dp_en
);

   typedef enum logic [2:0] {
      S_INPUT    = 3'b001,
      S_PLAYBACK = 3'b010,
      S_REPEAT   = 3'b100,
      S_DONE     = 3'b111
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] select_q, select_d;
   logic       w_en_q, w_en_d;
   logic       dp_en_q, dp_en_d;
   logic       sync1_q, sync2_q, prev_q;
   logic [1:0] warm_q, warm_d;
   logic       step_adv;
   logic       adv;

   if (AUTO_DIV < 1) begin : g_bad_auto_div
      $error("AUTO_DIV must be at least 1");
   end

   // Edge detection stays disarmed until the synchroniser and prev_q hold real samples,
   // so a button held through reset release never looks like a fresh press.
   always_comb begin
      warm_d   = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
      step_adv = sync2_q & ~prev_q & (warm_q == 2'd3);
   end

`ifdef SIMON_CTRL_AUTOPLAY_EN
   logic [AUTO_DIV-1:0] auto_q, auto_d;
   logic                auto_mode;

   always_comb begin
      auto_mode = (state_q == S_PLAYBACK) || (state_q == S_DONE);
      auto_d    = auto_mode ? auto_q + AUTO_DIV'(1) : '0;
      adv       = auto_mode ? (auto_q == '1) : step_adv;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) auto_q <= '0;
      else      auto_q <= auto_d;
   end
`else
   always_comb adv = step_adv;
`endif

   always_comb begin
      state_d = state_q;
      w_en_d  = 1'b0;
      dp_en_d = 1'b0;
      if (adv) begin
         dp_en_d = 1'b1;
         case (state_q)
            S_INPUT: begin
               if (is_legal) begin
                  w_en_d  = 1'b1;
                  state_d = S_PLAYBACK;
               end else begin
                  dp_en_d = 1'b0;
               end
            end
            S_PLAYBACK: if (play_gt_count) state_d = S_REPEAT;
            S_REPEAT: begin
               if (!input_eq_pattern)    state_d = S_DONE;
               else if (!repeat_eq_play) state_d = S_INPUT;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_INPUT;
         endcase
      end

      case (state_d)
         S_REPEAT: select_d = 2'b01;
         S_DONE:   select_d = 2'b10;
         default:  select_d = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_INPUT;
         select_q <= '0;
         w_en_q   <= 1'b0;
         dp_en_q  <= 1'b0;
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         prev_q   <= 1'b0;
         warm_q   <= '0;
      end else begin
         state_q  <= state_d;
         select_q <= select_d;
         w_en_q   <= w_en_d;
         dp_en_q  <= dp_en_d;
         sync1_q  <= step;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         warm_q   <= warm_d;
      end
   end

   assign mode_leds = state_q;
   assign select    = select_q;
   assign w_en      = w_en_q;
   assign dp_en     = dp_en_q;

endmodule

// File: tb/tb_simon_control.sv
// Directed bench for simon_control: strobe expectations queued at stimulus time, checked on dp_en.
module tb_simon_control;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       step = 1'b0;
   logic       is_legal = 1'b0;
   logic       play_gt_count = 1'b0;
   logic       repeat_eq_play = 1'b0;
   logic       input_eq_pattern = 1'b0;
   logic [1:0] select;
   logic [2:0] mode_leds;
   logic       w_en;
   logic       dp_en;

   typedef struct packed {
      logic       w;
      logic [2:0] mode;
      logic [1:0] sel;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   passed = 0;
   int   strobes = 0;
   int   cyc_cnt = 0;
   int   last_cyc = 0;
   int   intv = 0;
   int   s0;
   int   n;
   logic found;

   always #5 clk = ~clk;

`ifdef SIMON_CTRL_AUTOPLAY_EN
   simon_control #(.AUTO_DIV(4)) dut (
`else
   simon_control dut (
`endif
      .clk(clk), .rst(rst), .step(step), .is_legal(is_legal),
      .play_gt_count(play_gt_count), .repeat_eq_play(repeat_eq_play),
      .input_eq_pattern(input_eq_pattern), .select(select),
      .mode_leds(mode_leds), .w_en(w_en), .dp_en(dp_en)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_state(input string tag, input logic [2:0] m, input logic [1:0] s);
      chk({tag, "_mode"}, 32'(mode_leds), 32'(m));
      chk({tag, "_select"}, 32'(select), 32'(s));
   endtask

   task automatic cyc(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic w, input logic [2:0] m, input logic [1:0] s);
      sb.push_back({w, m, s});
   endtask

   task automatic press();
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      cyc(5);
   endtask

   always @(posedge clk) cyc_cnt++;

   always @(negedge clk) begin
      if (rst === 1'b1 && w_en === 1'b1 && dp_en !== 1'b1)
         chk("w_en_without_dp_en", 32'(dp_en), 32'd1);
      if (rst === 1'b1 && dp_en === 1'b1) begin
         strobes++;
         intv     = cyc_cnt - last_cyc;
         last_cyc = cyc_cnt;
         if (sb.size() == 0) begin
            chk("unexpected_strobe", 32'(dp_en), 32'd0);
         end else begin
            mon_e = sb.pop_front();
            chk("strobe_w_en", 32'(w_en), 32'(mon_e.w));
            chk("strobe_mode", 32'(mode_leds), 32'(mon_e.mode));
            chk("strobe_select", 32'(select), 32'(mon_e.sel));
         end
      end
   end

   initial begin
      rst = 1'b0;
      cyc(2);
      chk_state("reset", 3'b001, 2'b00);
      chk("reset_w_en", 32'(w_en), 32'd0);
      chk("reset_dp_en", 32'(dp_en), 32'd0);
      rst = 1'b1;
      cyc(4);

`ifdef SIMON_CTRL_AUTOPLAY_EN
      is_legal = 1'b1;
      push_exp(1'b1, 3'b010, 2'b00);
      press();
      chk_state("auto_enter_pb", 3'b010, 2'b00);
      is_legal = 1'b0;
      for (int k = 0; k < 3; k++) begin
         s0 = strobes;
         push_exp(1'b0, 3'b010, 2'b00);
         step = 1'b1;
         cyc(1);
         step = 1'b0;
         n = 0;
         while (strobes == s0 && n < 40) begin
            cyc(1);
            n++;
         end
         chk("auto_strobe_count", 32'(strobes - s0), 32'd1);
         chk("auto_interval", 32'(intv), 32'd16);
      end
      chk_state("auto_stays_pb", 3'b010, 2'b00);
`else
      // illegal entry: nothing happens
      is_legal = 1'b0;
      s0 = strobes;
      press();
      chk("illegal_no_strobe", 32'(strobes - s0), 32'd0);
      chk_state("illegal", 3'b001, 2'b00);

      // legal entry with latency
      is_legal = 1'b1;
      push_exp(1'b1, 3'b010, 2'b00);
      step = 1'b1;
      cyc(1);
      chk("lat_edge1_dp_en", 32'(dp_en), 32'd0);
      step = 1'b0;
      cyc(1);
      chk("lat_edge2_dp_en", 32'(dp_en), 32'd0);
      cyc(1);
      chk("lat_edge3_dp_en", 32'(dp_en), 32'd1);
      chk("lat_edge3_w_en", 32'(w_en), 32'd1);
      chk_state("legal", 3'b010, 2'b00);
      cyc(1);
      chk("lat_edge4_dp_en", 32'(dp_en), 32'd0);
      chk("lat_edge4_w_en", 32'(w_en), 32'd0);
      cyc(3);
      is_legal = 1'b0;

      // full round
      play_gt_count = 1'b0;
      push_exp(1'b0, 3'b010, 2'b00);
      press();
      chk_state("pb1", 3'b010, 2'b00);
      play_gt_count = 1'b1;
      push_exp(1'b0, 3'b100, 2'b01);
      press();
      chk_state("pb2", 3'b100, 2'b01);
      play_gt_count = 1'b0;
      input_eq_pattern = 1'b1;
      repeat_eq_play = 1'b1;
      push_exp(1'b0, 3'b100, 2'b01);
      press();
      chk_state("rp1", 3'b100, 2'b01);
      repeat_eq_play = 1'b0;
      push_exp(1'b0, 3'b001, 2'b00);
      press();
      chk_state("rp2", 3'b001, 2'b00);

      // flags moving without a press have no effect
      s0 = strobes;
      is_legal = 1'b1;
      play_gt_count = 1'b1;
      cyc(5);
      chk("flags_idle_no_strobe", 32'(strobes - s0), 32'd0);
      chk_state("flags_idle", 3'b001, 2'b00);

      // mismatch -> DONE, stays there
      push_exp(1'b1, 3'b010, 2'b00);
      press();
      push_exp(1'b0, 3'b100, 2'b01);
      press();
      play_gt_count = 1'b0;
      input_eq_pattern = 1'b0;
      repeat_eq_play = 1'b1;
      push_exp(1'b0, 3'b111, 2'b10);
      press();
      chk_state("mismatch", 3'b111, 2'b10);
      input_eq_pattern = 1'b1;
      repeat_eq_play = 1'b0;
      push_exp(1'b0, 3'b111, 2'b10);
      press();
      push_exp(1'b0, 3'b111, 2'b10);
      press();
      chk_state("done_stays", 3'b111, 2'b10);
      rst = 1'b0;
      #1;
      chk_state("done_reset", 3'b001, 2'b00);
      cyc(1);

      // held button gives a single advance
      rst = 1'b1;
      cyc(4);
      is_legal = 1'b1;
      s0 = strobes;
      push_exp(1'b1, 3'b010, 2'b00);
      step = 1'b1;
      cyc(100);
      step = 1'b0;
      cyc(5);
      chk("hold_one_strobe", 32'(strobes - s0), 32'd1);
      chk_state("hold", 3'b010, 2'b00);

      // reset while strobe is high
      is_legal = 1'b0;
      s0 = strobes;
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (dp_en === 1'b1) begin
            found = 1'b1;
            break;
         end
         cyc(1);
      end
      chk("midstrobe_seen", 32'(found), 32'd1);
      rst = 1'b0;
      #1;
      chk("midstrobe_dp_en", 32'(dp_en), 32'd0);
      chk_state("midstrobe", 3'b001, 2'b00);

      // button held through reset release
      step = 1'b1;
      cyc(2);
      rst = 1'b1;
      cyc(10);
      chk("release_held_no_strobe", 32'(strobes - s0), 32'd0);
      chk_state("release_held", 3'b001, 2'b00);
      step = 1'b0;
      cyc(5);
      is_legal = 1'b1;
      push_exp(1'b1, 3'b010, 2'b00);
      press();
      chk_state("after_release", 3'b010, 2'b00);
`endif

      cyc(2);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
